decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
- Parametrised, registered successor to the team's 3-to-8 enable-gated one-cold decoder.
- Direct mode: decodes address A to one active output line, registered with 1-cycle latency.
- Scan mode: an internal sequencer walks the active line across outputs 0..N-1. Each line is held active for DWELL cycles. Used for multiplexed display/row driving.
- Keeps the three-input enable gate: G1 active-high; GN2 and GN3 active-low.

Parameters:
- AW, 3, address width.
- N, 8, number of outputs. Legal range 2..2**AW.
- DWELL, 4, clocks each line stays active in scan mode. Must be ≥1.
- ACTIVE_LOW, 1. 1 means the active line is 0 and inactive lines are 1. 0 inverts this polarity.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous active-high reset.
- A  input  AW  decode address (direct mode).
- G1  input  1  enable, active-high.
- GN2  input  1  enable, active-low.
- GN3  input  1  enable, active-low.
- MODE  input  1  0 = direct decode, 1 = auto-scan.
- Y  output  N  registered decoder outputs.
- SEL  output  AW  registered index of the currently active line. Zero when no line is active.
- STEP  output  1  registered pulse, high during the last active cycle of each scan dwell.

Behaviour:
- Definitions:
  - EN = G1 & ~GN2 & ~GN3.
  - INACT = all N bits at the inactive level: all ones if ACTIVE_LOW=1, all zeros otherwise.
- Reset (RST=1 at an edge): Y=INACT, SEL=0, STEP=0, scan index idx=0, dwell counter cnt=0. Reset overrides every other input, including mid-dwell.
- Direct mode (MODE=0), at each edge:
  - If EN and A<N: Y = INACT with bit A at the active level; SEL=A.
  - Otherwise (disabled, or A≥N): Y=INACT, SEL=0.
  - STEP=0. idx and cnt are held at 0. Latency is one clock.
- Scan mode (MODE=1, EN=1), at each edge:
  - Y = INACT with bit idx active; SEL=idx.
  - If cnt==DWELL-1: STEP=1, cnt=0, and idx=idx+1. idx wraps from N-1 to 0.
  - Otherwise: STEP=0 and cnt=cnt+1.
  - Line k is therefore active for exactly DWELL consecutive cycles. Full period is N*DWELL cycles.
  - DWELL=1: the active line advances every cycle and STEP is held high.
- Scan mode, EN=0:
  - Y=INACT, SEL=0, STEP=0.
  - idx and cnt freeze.
  - When EN returns, the scan resumes the interrupted dwell with its remaining count.
- MODE change:
  - 0→1: idx=0, cnt=0 are loaded at that edge. The first scan output appears on the following edge.
  - 1→0: direct decoding takes effect at the same edge; idx and cnt are cleared.
- A is ignored in scan mode.
- Non-power-of-two N: idx never reaches N..2**AW-1.
- Counter widths: cnt is clog2(DWELL) bits, minimum 1.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DECODER_SCAN_BLANK_EN.
- Defined: in scan mode, one blanking cycle is inserted after each dwell, before the next line is driven.
  - During the blanking cycle: Y=INACT, SEL=0, STEP=0.
  - Period becomes N*(DWELL+1).
  - STEP still marks the last active cycle of each dwell.
  - EN=0 during blanking freezes the blank phase.
- Not defined: no blanking cycle; behaviour is exactly as above.
- Direct mode is identical either way.

Test Plan:
- Reset, then AW=3, N=8, ACTIVE_LOW=1, MODE=0, G1=1, GN2=0, GN3=0, A=5 → one edge later Y=8'b1101_1111, SEL=5, STEP=0. Sweep A=0..7: each line goes low one cycle after A is applied.
- Direct mode, A=3, toggle each gate individually (G1=0, then GN2=1, then GN3=1) → Y=8'hFF and SEL=0 one cycle later in each case. Restoring the gates gives Y=8'b1111_0111.
- MODE=1, DWELL=4, enabled → Y=8'hFE for 4 cycles with STEP high on the 4th, then 8'hFD, and so on. After 8'h7F, Y wraps to 8'hFE; cycle 33 shows line 0 again.
- Scan mode, drop G1 for 3 cycles during the 2nd cycle of line 2 → Y=8'hFF and idx/cnt frozen. On G1 restore, line 2 stays active for 2 more cycles, then line 3.
- Assert RST mid-dwell on line 6 → next edge Y=8'hFF, SEL=0. After release, scan restarts at line 0.
- With DECODER_SCAN_BLANK_EN defined and DWELL=2 → pattern is FE, FE, FF, FD, FD, FF, …; STEP high on the 2nd FE and 2nd FD cycles.

Source files
------------

// File: rtl/decoder_scan.sv
// ----------------------------------------------------------------------------
// decoder_scan
//   Registered one-of-N decoder with an optional auto-scan sequencer. It is the
//   parametrised successor to the 3-to-8 enable-gated one-cold decoder.
//
//   Direct mode (MODE=0): Y drives line A at the active level one clock after
//   A is applied, provided the gate is open (G1 & ~GN2 & ~GN3) and A < N.
//   Scan mode   (MODE=1): the active line walks 0..N-1. Each line is held for
//   DWELL clocks, and STEP marks the last cycle of each dwell. While the gate
//   is closed the outputs go inactive and the sequencer freezes.
//
//   Optional build macro DECODER_SCAN_BLANK_EN: adds one blank (all-inactive)
//   cycle after every dwell in scan mode.
//
// Ports
//   CLK   in   1   clock, rising edge
//   RST   in   1   synchronous active-high reset
//   A     in   AW  direct-mode address
//   G1    in   1   enable, active-high
//   GN2   in   1   enable, active-low
//   GN3   in   1   enable, active-low
//   MODE  in   1   0 = direct decode, 1 = auto-scan
//   Y     out  N   registered decoder lines
//   SEL   out  AW  registered index of the active line, 0 when none is active
//   STEP  out  1   registered pulse on the last active cycle of each dwell
// ----------------------------------------------------------------------------
module decoder_scan #(
    parameter int AW         = 3,
    parameter int N          = 8,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] A,
    input  logic          G1,
    input  logic          GN2,
    input  logic          GN3,
    input  logic          MODE,
    output logic [N-1:0]  Y,
    output logic [AW-1:0] SEL,
    output logic          STEP
);

    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [N-1:0]  INACT    = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    // ST_DIRECT : last edge was in direct mode; a MODE=1 edge from here is the
    //             load edge (idx/cnt cleared, outputs still inactive).
    // ST_SCAN   : driving line idx, counting the dwell.
    // ST_BLANK  : blank cycle between dwells (reachable only with blanking).
    typedef enum logic [1:0] {
        ST_DIRECT = 2'd0,
        ST_SCAN   = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  y_d;
    logic [AW-1:0] sel_d;
    logic          step_d;

    logic en;
    logic a_ok;
    logic dwell_done;

    assign en         = G1 & ~GN2 & ~GN3;
    assign a_ok       = ({1'b0, A} < (AW + 1)'(N));
    assign dwell_done = (cnt_q == CNT_LAST);

    // Flip the chosen bit of the inactive pattern to the active level.
    function automatic logic [N-1:0] line_of(input logic [AW-1:0] i);
        line_of = INACT ^ (N'(1) << i);
    endfunction

    // State and output registers. Reset leaves the sequencer armed at line 0,
    // so a scan held through reset starts on the first edge after release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
            cnt_q   <= '0;
            Y       <= INACT;
            SEL     <= '0;
            STEP    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            Y       <= y_d;
            SEL     <= sel_d;
            STEP    <= step_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!MODE) begin
            state_d = ST_DIRECT;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DIRECT: begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_SCAN: begin
                    if (en) begin
                        if (dwell_done) begin
                            cnt_d = '0;
                            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
`ifdef DECODER_SCAN_BLANK_EN
                            state_d = ST_BLANK;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    if (en) begin
                        state_d = ST_SCAN;
                    end
                end
                default: begin
                    state_d = ST_DIRECT;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: value the output registers take at the coming edge.
    always_comb begin
        y_d    = INACT;
        sel_d  = '0;
        step_d = 1'b0;
        if (!MODE) begin
            if (en && a_ok) begin
                y_d   = line_of(A);
                sel_d = A;
            end
        end else if (state_q == ST_SCAN && en) begin
            y_d    = line_of(idx_q);
            sel_d  = idx_q;
            step_d = dwell_done;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

    localparam int AW         = 3;
    localparam int N          = 8;
    localparam int DWELL      = 4;
    localparam int ACTIVE_LOW = 1;
`ifdef DECODER_SCAN_BLANK_EN
    localparam int SLOT = DWELL + 1;
`else
    localparam int SLOT = DWELL;
`endif
    localparam int PERIOD = N * SLOT;
    localparam int EW     = N + AW + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] A;
    logic          G1, GN2, GN3, MODE;
    logic [N-1:0]  Y;
    logic [AW-1:0] SEL;
    logic          STEP;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected {Y, SEL, STEP} per edge.
    logic [EW-1:0] exp_q[$];

    // Reference model state: position within the scan period and whether the
    // sequencer is live (false right after a direct-mode edge).
    int pos  = 0;
    bit live = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    decoder_scan #(
        .AW(AW), .N(N), .DWELL(DWELL), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .CLK(CLK), .RST(RST), .A(A), .G1(G1), .GN2(GN2), .GN3(GN3),
        .MODE(MODE), .Y(Y), .SEL(SEL), .STEP(STEP)
    );

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [N-1:0] line_y(input int k);
        logic [N-1:0] v;
        v    = {N{1'b1}};
        v[k] = 1'b0;
        return v;
    endfunction

    // Behavioural model of one clock edge using the inputs present at it.
    task automatic model_step();
        logic [N-1:0]  ey;
        logic [AW-1:0] es;
        logic          est;
        bit            en;
        int            k, r;
        ey  = {N{1'b1}};
        es  = '0;
        est = 1'b0;
        en  = G1 && !GN2 && !GN3;
        if (RST) begin
            pos  = 0;
            live = 1'b1;
        end else if (!MODE) begin
            pos  = 0;
            live = 1'b0;
            if (en && int'(A) < N) begin
                ey = line_y(int'(A));
                es = A;
            end
        end else if (!live) begin
            live = 1'b1;
            pos  = 0;
        end else if (en) begin
            k = pos / SLOT;
            r = pos % SLOT;
            if (r < DWELL) begin
                ey  = line_y(k);
                es  = AW'(k);
                est = (r == DWELL - 1);
            end
            pos = (pos + 1) % PERIOD;
        end
        exp_q.push_back({ey, es, est});
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        logic [EW-1:0] e;
        @(posedge CLK);
        model_step();
        #1;
        e = exp_q.pop_front();
        chk("y_model",    32'(Y),    32'(e[EW-1:AW+1]));
        chk("sel_model",  32'(SEL),  32'(e[AW:1]));
        chk("step_model", 32'(STEP), 32'(e[0]));
    endtask

    task automatic restart_scan();
        MODE = 1'b0;
        tick();
        MODE = 1'b1;
        tick();
        chk("load_y", 32'(Y), 32'h0000_00FF);
    endtask

    typedef struct {
        logic       g1, gn2, gn3;
        logic [2:0] a;
        logic [7:0] y;
        logic [2:0] sel;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;

        // Direct-mode vectors.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd5, 8'b1101_1111, 3'd5});
        for (int i = 0; i < 8; i++) begin
            v.g1 = 1'b1; v.gn2 = 1'b0; v.gn3 = 1'b0;
            v.a = 3'(i); v.y = 8'hFF ^ (8'h01 << i); v.sel = 3'(i);
            vecs.push_back(v);
        end
        vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd3, 8'hFF, 3'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd3, 8'hFF, 3'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd3, 8'hFF, 3'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd3, 8'b1111_0111, 3'd3});

        RST = 1'b1; MODE = 1'b0; G1 = 1'b1; GN2 = 1'b0; GN3 = 1'b0; A = '0;
        tick();
        tick();
        chk("rst_y",    32'(Y),    32'h0000_00FF);
        chk("rst_sel",  32'(SEL),  32'd0);
        chk("rst_step", 32'(STEP), 32'd0);
        RST = 1'b0;

        // Direct mode table.
        foreach (vecs[i]) begin
            G1 = vecs[i].g1; GN2 = vecs[i].gn2; GN3 = vecs[i].gn3; A = vecs[i].a;
            tick();
            chk("vec_y",    32'(Y),    32'(vecs[i].y));
            chk("vec_sel",  32'(SEL),  32'(vecs[i].sel));
            chk("vec_step", 32'(STEP), 32'd0);
        end

        // Full scan period with wrap back to line 0.
        G1 = 1'b1; GN2 = 1'b0; GN3 = 1'b0;
        restart_scan();
        for (int c = 0; c <= PERIOD; c++) begin
            tick();
            if (c == 0)         chk("scan_first_y", 32'(Y), 32'h0000_00FE);
            if (c == DWELL - 1) chk("scan_step",    32'(STEP), 32'd1);
            if (c == SLOT)      chk("scan_line1_y", 32'(Y), 32'h0000_00FD);
            if (c == PERIOD)    chk("scan_wrap_y",  32'(Y), 32'h0000_00FE);
        end

        // Gate dropped during the 2nd cycle of line 2.
        restart_scan();
        for (int c = 0; c < 2 * SLOT + 2; c++) tick();
        chk("pre_drop_y", 32'(Y), 32'h0000_00FB);
        G1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("drop_y",   32'(Y),   32'h0000_00FF);
            chk("drop_sel", 32'(SEL), 32'd0);
        end
        G1 = 1'b1;
        tick();
        chk("resume1_y",    32'(Y),    32'h0000_00FB);
        chk("resume1_step", 32'(STEP), 32'd0);
        tick();
        chk("resume2_y",    32'(Y),    32'h0000_00FB);
        chk("resume2_step", 32'(STEP), 32'd1);
        for (int c = 0; c < SLOT - DWELL; c++) tick();
        tick();
        chk("line3_y",   32'(Y),   32'h0000_00F7);
        chk("line3_sel", 32'(SEL), 32'd3);

        // Reset mid-dwell on line 6.
        restart_scan();
        for (int c = 0; c < 6 * SLOT + 2; c++) tick();
        chk("line6_y", 32'(Y), 32'h0000_00BF);
        RST = 1'b1;
        tick();
        chk("midrst_y",    32'(Y),    32'h0000_00FF);
        chk("midrst_sel",  32'(SEL),  32'd0);
        chk("midrst_step", 32'(STEP), 32'd0);
        RST = 1'b0;
        tick();
        chk("postrst_y",   32'(Y),   32'h0000_00FE);
        chk("postrst_sel", 32'(SEL), 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 149) == 0) MODE = ~MODE;
            G1  = ($urandom_range(0, 9) != 0);
            GN2 = ($urandom_range(0, 24) == 0);
            GN3 = ($urandom_range(0, 24) == 0);
            A   = AW'($urandom_range(0, (1 << AW) - 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
